// File: rtl/window_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_sum_accumulator                                                   |
// | Sums NUM_SAMPLES 33-bit adder outputs per window into a 2-entry buffer.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module window_sum_accumulator #(
  parameter int NUM_SAMPLES = 16,
  parameter int ACC_W       = 40,
  localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             sysclk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [31:0]      in_result,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count,
  output logic             drop_flag
);

  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [1:0]       C_EMPTY = 2'd0;
  localparam logic [1:0]       C_ONE   = 2'd1;
  localparam logic [1:0]       C_FULL  = 2'd2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wovf_q, wovf_d;
  logic [1:0]       occ_q, occ_d;
  logic [ACC_W-1:0] head_sum_q, head_sum_d;
  logic             head_ovf_q, head_ovf_d;
  logic [ACC_W-1:0] tail_sum_q, tail_sum_d;
  logic             tail_ovf_q, tail_ovf_d;
  logic             drop_q, drop_d;

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W:0]   w_add;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic [ACC_W-1:0] w_new_sum;
  logic             w_new_ovf;

  always_comb begin
    w_sample       = '0;
    w_sample[32:0] = {in_carry, in_result};
  end

  // Extra MSB of the add is the carry-out past ACC_W.
  assign w_add     = {1'b0, acc_q} + {1'b0, w_sample};
  assign w_new_sum = w_add[ACC_W-1:0];
  assign w_new_ovf = wovf_q | w_add[ACC_W];
  assign w_last    = (cnt_q == C_LAST);
  assign w_push    = in_valid && !clear && w_last;
  assign w_pop     = (occ_q != C_EMPTY) && out_ready && !clear;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wovf_d = wovf_q;
    if (clear || (in_valid && w_last)) begin
      acc_d  = '0;
      cnt_d  = '0;
      wovf_d = 1'b0;
    end else if (in_valid) begin
      acc_d  = w_new_sum;
      cnt_d  = cnt_q + CNT_W'(1);
      wovf_d = w_new_ovf;
    end
  end

  // Head register feeds the outputs directly; tail only holds the second entry.
  always_comb begin
    occ_d      = occ_q;
    head_sum_d = head_sum_q;
    head_ovf_d = head_ovf_q;
    tail_sum_d = tail_sum_q;
    tail_ovf_d = tail_ovf_q;
    drop_d     = drop_q;
    if (clear) begin
      occ_d      = C_EMPTY;
      head_sum_d = '0;
      head_ovf_d = 1'b0;
      tail_sum_d = '0;
      tail_ovf_d = 1'b0;
      drop_d     = 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          case (occ_q)
            C_EMPTY: begin
              head_sum_d = w_new_sum;
              head_ovf_d = w_new_ovf;
              occ_d      = C_ONE;
            end
            C_ONE: begin
              tail_sum_d = w_new_sum;
              tail_ovf_d = w_new_ovf;
              occ_d      = C_FULL;
            end
            default: drop_d = 1'b1;
          endcase
        end
        2'b01: begin
          if (occ_q == C_FULL) begin
            head_sum_d = tail_sum_q;
            head_ovf_d = tail_ovf_q;
            occ_d      = C_ONE;
          end else begin
            occ_d = C_EMPTY;
          end
        end
        2'b11: begin
          if (occ_q == C_FULL) begin
            head_sum_d = tail_sum_q;
            head_ovf_d = tail_ovf_q;
            tail_sum_d = w_new_sum;
            tail_ovf_d = w_new_ovf;
          end else begin
            head_sum_d = w_new_sum;
            head_ovf_d = w_new_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      wovf_q     <= 1'b0;
      occ_q      <= C_EMPTY;
      head_sum_q <= '0;
      head_ovf_q <= 1'b0;
      tail_sum_q <= '0;
      tail_ovf_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wovf_q     <= wovf_d;
      occ_q      <= occ_d;
      head_sum_q <= head_sum_d;
      head_ovf_q <= head_ovf_d;
      tail_sum_q <= tail_sum_d;
      tail_ovf_q <= tail_ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid    = (occ_q != C_EMPTY);
  assign out_sum      = head_sum_q;
  assign out_overflow = head_ovf_q;
  assign out_count    = cnt_q;
  assign drop_flag    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_window_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_window_sum_accumulator                                                |
// | Directed checks of window_sum_accumulator for N=4/W=40, N=4/W=34, N=1.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_window_sum_accumulator;

  logic        sysclk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_carry = 1'b0;
  logic [31:0] in_result = '0;
  logic        va = 1'b0, vb = 1'b0, vc = 1'b0;

  logic        a_valid, a_ovf, a_drop;
  logic [39:0] a_sum;
  logic [2:0]  a_cnt;
  logic        b_valid, b_ovf, b_drop;
  logic [33:0] b_sum;
  logic [2:0]  b_cnt;
  logic        c_valid, c_ovf, c_drop;
  logic [39:0] c_sum;
  logic [0:0]  c_cnt;

  int errors = 0;
  int checks = 0;

  always #5 sysclk = ~sysclk;

  window_sum_accumulator #(.NUM_SAMPLES(4), .ACC_W(40)) u_a (
    .sysclk(sysclk), .rstn(rstn), .in_valid(va), .in_carry(in_carry),
    .in_result(in_result), .clear(clear), .out_valid(a_valid),
    .out_ready(out_ready), .out_sum(a_sum), .out_overflow(a_ovf),
    .out_count(a_cnt), .drop_flag(a_drop)
  );

  window_sum_accumulator #(.NUM_SAMPLES(4), .ACC_W(34)) u_b (
    .sysclk(sysclk), .rstn(rstn), .in_valid(vb), .in_carry(in_carry),
    .in_result(in_result), .clear(clear), .out_valid(b_valid),
    .out_ready(out_ready), .out_sum(b_sum), .out_overflow(b_ovf),
    .out_count(b_cnt), .drop_flag(b_drop)
  );

  window_sum_accumulator #(.NUM_SAMPLES(1), .ACC_W(40)) u_c (
    .sysclk(sysclk), .rstn(rstn), .in_valid(vc), .in_carry(in_carry),
    .in_result(in_result), .clear(clear), .out_valid(c_valid),
    .out_ready(out_ready), .out_sum(c_sum), .out_overflow(c_ovf),
    .out_count(c_cnt), .drop_flag(c_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input int which, input logic [32:0] v);
    {in_carry, in_result} = v;
    va = (which == 0);
    vb = (which == 1);
    vc = (which == 2);
    tick();
    va = 1'b0;
    vb = 1'b0;
    vc = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_sum",   64'(a_sum),   64'd0);
    check("rst_ovf",   64'(a_ovf),   64'd0);
    check("rst_cnt",   64'(a_cnt),   64'd0);
    check("rst_drop",  64'(a_drop),  64'd0);
    rstn = 1'b1;

    // Consecutive samples 1..4
    out_ready = 1'b1;
    push(0, 33'd1);
    push(0, 33'd2);
    push(0, 33'd3);
    check("t1_cnt3",   64'(a_cnt),   64'd3);
    check("t1_novld",  64'(a_valid), 64'd0);
    push(0, 33'd4);
    check("t1_valid",  64'(a_valid), 64'd1);
    check("t1_sum",    64'(a_sum),   64'd10);
    check("t1_ovf",    64'(a_ovf),   64'd0);
    check("t1_cnt0",   64'(a_cnt),   64'd0);
    tick();
    check("t1_popped", 64'(a_valid), 64'd0);

    // Carry-only samples with idle gaps
    for (int i = 0; i < 4; i++) begin
      push(0, 33'h1_0000_0000);
      if (i == 1) check("t2_cnt2", 64'(a_cnt), 64'd2);
      if (i < 3) repeat (3) tick();
    end
    check("t2_valid", 64'(a_valid), 64'd1);
    check("t2_sum",   64'(a_sum),   64'h4_0000_0000);
    check("t2_ovf",   64'(a_ovf),   64'd0);
    tick();

    // Stalled sink: third window dropped
    out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 4; s++) push(0, 33'd1);
      if (w == 0) check("t3_drop0", 64'(a_drop), 64'd0);
    end
    check("t3_drop1",  64'(a_drop),  64'd1);
    check("t3_valid",  64'(a_valid), 64'd1);
    check("t3_head",   64'(a_sum),   64'd4);
    out_ready = 1'b1;
    tick();
    check("t3_second_vld", 64'(a_valid), 64'd1);
    check("t3_second_sum", 64'(a_sum),   64'd4);
    tick();
    check("t3_empty",  64'(a_valid), 64'd0);
    check("t3_sticky", 64'(a_drop),  64'd1);

    // Full buffer, pop and push in the same cycle
    do_clear();
    check("t4_clr_vld",  64'(a_valid), 64'd0);
    check("t4_clr_drop", 64'(a_drop),  64'd0);
    out_ready = 1'b0;
    for (int s = 0; s < 8; s++) push(0, 33'd1);
    for (int s = 0; s < 3; s++) push(0, 33'd2);
    out_ready = 1'b1;
    check("t4_xfer1", 64'(a_sum), 64'd4);
    push(0, 33'd2);
    check("t4_nodrop", 64'(a_drop),  64'd0);
    check("t4_vld2",   64'(a_valid), 64'd1);
    check("t4_xfer2",  64'(a_sum),   64'd4);
    tick();
    check("t4_vld3",   64'(a_valid), 64'd1);
    check("t4_xfer3",  64'(a_sum),   64'd8);
    tick();
    check("t4_empty",  64'(a_valid), 64'd0);

    // Narrow accumulator wraps
    do_clear();
    for (int s = 0; s < 4; s++) push(1, 33'h1_FFFF_FFFF);
    check("t5_valid", 64'(b_valid), 64'd1);
    check("t5_sum",   64'(b_sum),   64'h3_FFFF_FFFC);
    check("t5_ovf",   64'(b_ovf),   64'd1);
    for (int s = 0; s < 4; s++) push(1, 33'd1);
    check("t5_sum2",  64'(b_sum),   64'd4);
    check("t5_ovf2",  64'(b_ovf),   64'd0);

    // Single-sample windows, push and pop at occupancy 1
    push(2, 33'd7);
    check("n1_valid", 64'(c_valid), 64'd1);
    check("n1_sum",   64'(c_sum),   64'd7);
    check("n1_cnt",   64'(c_cnt),   64'd0);
    push(2, 33'd9);
    check("n1_valid2", 64'(c_valid), 64'd1);
    check("n1_sum2",   64'(c_sum),   64'd9);
    tick();
    check("n1_empty",  64'(c_valid), 64'd0);

    // Clear discards same-cycle sample
    do_clear();
    push(0, 33'd3);
    push(0, 33'd3);
    check("t6_cnt2", 64'(a_cnt), 64'd2);
    clear = 1'b1;
    {in_carry, in_result} = 33'd9;
    va = 1'b1;
    tick();
    va = 1'b0;
    clear = 1'b0;
    check("t6_cnt0",  64'(a_cnt),   64'd0);
    check("t6_novld", 64'(a_valid), 64'd0);
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) push(0, 33'd5);
    check("t6_valid", 64'(a_valid), 64'd1);
    check("t6_sum",   64'(a_sum),   64'd20);
    push(0, 33'd1);
    check("t6_cnt1",  64'(a_cnt),   64'd1);

    // Asynchronous reset between clock edges
    #3;
    rstn = 1'b0;
    #1;
    check("ar_valid", 64'(a_valid), 64'd0);
    check("ar_sum",   64'(a_sum),   64'd0);
    check("ar_ovf",   64'(a_ovf),   64'd0);
    check("ar_cnt",   64'(a_cnt),   64'd0);
    check("ar_drop",  64'(a_drop),  64'd0);
    #10;
    rstn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_sum_accumulator.md
Name: window_sum_accumulator

Overview:
Downstream consumer of the two-stage adder-pair pipeline's 33-bit output {carry, result}. Accumulates NUM_SAMPLES qualified sums into one window total and flags overflow. Completed totals are queued in a 2-entry output buffer with a valid/ready handshake, so a stalled sink does not stall the adder pipeline. The adder has no valid signal, so the integrator drives in_valid from a 2-cycle delayed copy of the adder input qualifier.

Parameters:
NUM_SAMPLES, 16, samples per window; legal range >= 1.
ACC_W, 40, accumulator and output sum width; legal range >= 33.

Ports:
sysclk  input  1  clock; all state on rising edge.
rstn  input  1  asynchronous active-low reset.
in_valid  input  1  in_carry/in_result hold a sample this cycle.
in_carry  input  1  MSB (bit 32) of the upstream sum.
in_result  input  32  bits 31:0 of the upstream sum.
clear  input  1  synchronous flush of window state, buffer and sticky flag.
out_valid  output  1  buffer head is valid.
out_ready  input  1  sink accepts the head this cycle.
out_sum  output  ACC_W  window total at the buffer head.
out_overflow  output  1  head window wrapped ACC_W.
out_count  output  ceil(log2(NUM_SAMPLES+1))  samples accumulated in the current window.
drop_flag  output  1  sticky: a completed window was lost because the buffer was full.

Behaviour:
- Reset (rstn low, asynchronous): acc=0, count=0, window overflow=0, buffer empty. Outputs out_valid=0, out_sum=0, out_overflow=0, out_count=0, drop_flag=0. Reset mid-window or mid-handshake discards everything immediately.
- Sample value: v = {in_carry, in_result}, zero-extended to ACC_W.
- in_valid=1 and count < NUM_SAMPLES-1: acc <= acc+v mod 2^ACC_W. Window overflow bit |= carry-out of that add. count <= count+1.
- in_valid=1 and count == NUM_SAMPLES-1 (window completes):
  - Push {acc+v mod 2^ACC_W, window overflow | carry-out} to the buffer.
  - acc <= 0, count <= 0, window overflow <= 0.
  - NUM_SAMPLES=1: every valid sample completes a window.
- Buffer: 2-entry FIFO, registered outputs.
  - out_valid = non-empty. out_sum and out_overflow show the head entry.
  - Pop when out_valid and out_ready.
  - A push is accepted when the buffer is not full, or when it is full and a pop happens in the same cycle (simultaneous push and pop while full is legal; occupancy stays 2).
  - Push while full with no pop: the entry is dropped, drop_flag <= 1, and buffer contents are unchanged.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1, and the new entry becomes head next cycle.
- Latency: a window completing at edge k gives out_valid=1 after edge k if the buffer was empty. Entries leave strictly in completion order.
- out_sum and out_overflow hold stable while out_valid=1 and out_ready=0. out_valid never deasserts without a pop, except on clear or reset.
- clear=1 (synchronous, highest priority):
  - acc, count, window overflow <= 0. Buffer emptied; out_valid=0 next cycle. drop_flag <= 0.
  - A same-cycle in_valid sample is discarded.
  - A same-cycle out_ready does not count as a transfer.
- in_valid=0: no state change in the accumulator. Idle gaps of any length inside a window are allowed.
- out_count reflects the registered count (0 .. NUM_SAMPLES-1).

Test Plan:
1. NUM_SAMPLES=4, ACC_W=40, out_ready=1. Samples 1,2,3,4 on consecutive cycles -> out_valid=1 for one cycle after the 4th edge. out_sum=10, out_overflow=0, out_count back to 0.
2. Four samples with in_carry=1, in_result=0, and idle gaps of 3 cycles between them -> out_sum=0x4_0000_0000, out_overflow=0.
3. out_ready=0; three windows of samples 1,1,1,1 -> two entries of 4 held, drop_flag=1 after the 3rd completion. Then out_ready=1 -> exactly two transfers of 4, out_valid falls, drop_flag stays 1.
4. Buffer full (two entries) and out_ready=1 in the cycle the next window completes -> push accepted, drop_flag stays 0. Three transfers occur in order with values 4,4,8 (third window samples 2,2,2,2).
5. ACC_W=34; four samples of 0x1_FFFF_FFFF -> out_sum=0x3_FFFF_FFFC, out_overflow=1. The next window of 1,1,1,1 -> out_sum=4, out_overflow=0.
6. Two samples accumulated, then clear=1 together with in_valid (value 9) -> out_count=0 and the sample is ignored. Samples 5,5,5,5 -> out_sum=20. Separately, pulse rstn low while out_valid=1 -> out_valid drops asynchronously and all outputs read 0.
